// File: rtl/spi_receptor_bits_pkg.sv
// Shared types and constants for the SPI frame receiver.
// Optional feature macro: SPI_RX_PARITY_EN (adds one trailing odd-parity bit per frame).
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    DONE
  } rx_state_t;

  localparam int DATA_BITS_DEF = 10;
  localparam int SYNC_DEPTH    = 2;

`ifdef SPI_RX_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

endpackage

// File: rtl/spi_receptor_bits_if.sv
// Receive-side handshake bundle between the SPI frame receiver and the core.
interface spi_receptor_bits_if #(
  parameter int DATA_BITS = spi_pkg::DATA_BITS_DEF
) ();

  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 frame_err;
  logic                 overrun;
  logic                 parity_err;

  modport master (
    output rx_data,
    output rx_valid,
    output frame_err,
    output overrun,
    output parity_err,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  frame_err,
    input  overrun,
    input  parity_err,
    output rx_ready
  );

endinterface

// File: rtl/spi_receptor_bits_sync_edge.sv
// Multi-flop synchroniser for asynchronous pins plus rising-edge detect on one of them.
module spi_sync_edge
  import spi_pkg::*;
#(
  parameter int NDATA = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_edge_async,
  input  logic [NDATA-1:0] i_async,
  output logic             o_rise,
  output logic [NDATA-1:0] o_sync
);

  logic [NDATA:0] r_sync [SYNC_DEPTH];
  logic           r_prev;
  logic [NDATA:0] w_out;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < SYNC_DEPTH; i++) r_sync[i] <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync[0] <= {i_async, i_edge_async};
      for (int unsigned i = 1; i < SYNC_DEPTH; i++) r_sync[i] <= r_sync[i-1];
      r_prev <= r_sync[SYNC_DEPTH-1][0];
    end
  end

  // Data channels leave at the same stage as the edge so sampled bits align with o_rise.
  assign w_out  = r_sync[SYNC_DEPTH-1];
  assign o_rise = w_out[0] & ~r_prev;
  assign o_sync = w_out[NDATA:1];

endmodule

// File: rtl/spi_receptor_bits.sv
// SPI slave frame receiver: syncs pins, shifts mosi MSB-first, hands frames over valid/ready.
// Optional feature macro: SPI_RX_PARITY_EN (trailing odd-parity bit, parity_err pulse).
module spi_receptor_bits
  import spi_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEF,
  parameter int CNT_W     = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sclk,
  input  logic                cs_n,
  input  logic                mosi,
  spi_receptor_bits_if.master rx
);

  localparam int FRAME_BITS = DATA_BITS + PARITY_BITS;

  rx_state_t              r_state, w_state_n;
  logic [CNT_W-1:0]       r_cnt, w_cnt_n, w_cnt_inc;
  logic [FRAME_BITS-1:0]  r_shreg, w_shreg_n;
  logic [DATA_BITS-1:0]   r_data, w_data_n;
  logic                   r_valid, w_valid_n;
  logic                   r_ovr, w_ovr_n;
  logic                   r_ferr, w_ferr_n;
  logic                   w_load;
  logic                   w_rise, w_cs_n, w_mosi;
  logic [1:0]             w_sync;

  spi_sync_edge #(.NDATA(2)) u_sync (
    .clk          (clk),
    .rst          (rst),
    .i_edge_async (sclk),
    .i_async      ({mosi, cs_n}),
    .o_rise       (w_rise),
    .o_sync       (w_sync)
  );

  assign w_cs_n    = w_sync[0];
  assign w_mosi    = w_sync[1];
  assign w_cnt_inc = r_cnt + CNT_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_shreg <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_shreg <= w_shreg_n;
      r_data  <= w_data_n;
      r_valid <= w_valid_n;
      r_ovr   <= w_ovr_n;
      r_ferr  <= w_ferr_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_shreg_n = r_shreg;
    w_data_n  = r_data;
    w_valid_n = r_valid;
    w_ovr_n   = r_ovr;
    w_ferr_n  = 1'b0;
    w_load    = 1'b0;

    if (r_valid && rx.rx_ready) begin
      w_valid_n = 1'b0;
      w_ovr_n   = 1'b0;
    end

    unique case (r_state)
      IDLE: begin
        w_cnt_n = '0;
        if (!w_cs_n) w_state_n = RECV;
      end
      RECV: begin
        if (w_cs_n) begin
          // cs_n high with no bits yet is the normal end after a back-to-back frame
          w_ferr_n  = (r_cnt != '0);
          w_cnt_n   = '0;
          w_state_n = IDLE;
        end else if (w_rise) begin
          w_shreg_n = {r_shreg[FRAME_BITS-2:0], w_mosi};
          w_cnt_n   = w_cnt_inc;
          if (w_cnt_inc == CNT_W'(FRAME_BITS)) w_state_n = DONE;
        end
      end
      DONE: begin
        w_cnt_n = '0;
        if (!r_valid || rx.rx_ready) begin
          w_load    = 1'b1;
          w_data_n  = r_shreg[FRAME_BITS-1 -: DATA_BITS];
          w_valid_n = 1'b1;
        end else begin
          w_ovr_n = 1'b1;
        end
        w_state_n = w_cs_n ? IDLE : RECV;
      end
      default: w_state_n = IDLE;
    endcase
  end

`ifdef SPI_RX_PARITY_EN
  logic r_perr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_perr <= 1'b0;
    else      r_perr <= w_load & ~(^r_shreg);
  end

  assign rx.parity_err = r_perr;
`else
  assign rx.parity_err = 1'b0;
`endif

  assign rx.rx_data   = r_data;
  assign rx.rx_valid  = r_valid;
  assign rx.overrun   = r_ovr;
  assign rx.frame_err = r_ferr;

endmodule

// File: tb/tb_spi_receptor_bits.sv
// Scoreboard bench for spi_receptor_bits: directed SPI frames, monitor pops on each accept.
module tb_spi_receptor_bits;
  import spi_pkg::*;

  typedef struct packed {
    logic [9:0] data;
    logic       perr;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sclk = 1'b0;
  logic cs_n = 1'b1;
  logic mosi = 1'b0;

  int checks = 0;
  int errors = 0;
  int rise_cnt = 0;
  int ferr_cnt = 0;
  int perr_cnt = 0;
  logic prev_valid = 1'b0;
  logic cap_perr = 1'b0;
  exp_t sb[$];

  spi_receptor_bits_if #(.DATA_BITS(10)) rx_if ();

  spi_receptor_bits #(.DATA_BITS(10), .CNT_W(4)) dut (
    .clk  (clk),
    .rst  (rst_n),
    .sclk (sclk),
    .cs_n (cs_n),
    .mosi (mosi),
    .rx   (rx_if)
  );

  always #5 clk = ~clk;

  // Monitor: track pulses and pop the scoreboard whenever a frame is accepted.
  always @(negedge clk) begin
    exp_t e;
    if (rx_if.rx_valid && !prev_valid) begin
      rise_cnt++;
      cap_perr = rx_if.parity_err;
    end
    if (rx_if.parity_err) perr_cnt++;
    if (rx_if.frame_err) ferr_cnt++;
    if (rx_if.rx_valid && rx_if.rx_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got data %0h with no frame expected", rx_if.rx_data);
      end else begin
        e = sb.pop_front();
        if (rx_if.rx_data !== e.data || cap_perr !== e.perr) begin
          errors++;
          $display("FAIL sb_frame: got data %0h perr %0b, expected data %0h perr %0b",
                   rx_if.rx_data, cap_perr, e.data, e.perr);
        end
      end
    end
    prev_valid = rx_if.rx_valid;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    sclk = 1'b0;
    mosi = b;
    #40;
    sclk = 1'b1;
    #40;
  endtask

  function automatic logic good_par(input logic [9:0] d);
    return ~(^d);
  endfunction

  task automatic send_frame(input logic [9:0] d, input logic p);
    for (int i = 9; i >= 0; i--) send_bit(d[i]);
`ifdef SPI_RX_PARITY_EN
    send_bit(p);
`else
    if (p) mosi = 1'b0;
`endif
    sclk = 1'b0;
    #40;
  endtask

  task automatic wait_empty(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s: timeout, %0d frames still pending, expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic push(input logic [9:0] d, input logic pe);
    exp_t e;
    e.data = d;
    e.perr = pe;
    sb.push_back(e);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, f0, p0;
    rx_if.rx_ready = 1'b1;
    #23;
    chk("reset_data", 32'(rx_if.rx_data), 32'h0);
    chk("reset_valid", 32'(rx_if.rx_valid), 32'h0);
    chk("reset_ovr", 32'(rx_if.overrun), 32'h0);
    chk("reset_ferr", 32'(rx_if.frame_err), 32'h0);
    chk("reset_perr", 32'(rx_if.parity_err), 32'h0);
    rst_n = 1'b1;
    #100;

    // 1: single frame, core always ready
    r0 = rise_cnt; f0 = ferr_cnt;
    cs_n = 1'b0; #100;
    push(10'h2A5, 1'b0);
    send_frame(10'h2A5, good_par(10'h2A5));
    wait_empty("t1_drain");
    cs_n = 1'b1; #200;
    chk("t1_rise_once", 32'(rise_cnt - r0), 32'd1);
    chk("t1_no_ferr", 32'(ferr_cnt - f0), 32'd0);

    // 2: back-to-back frames with core stalled -> overrun, old data kept
    rx_if.rx_ready = 1'b0;
    r0 = rise_cnt;
    cs_n = 1'b0; #100;
    send_frame(10'h3FF, good_par(10'h3FF));
    send_frame(10'h001, good_par(10'h001));
    #100;
    chk("t2_data_kept", 32'(rx_if.rx_data), 32'h3FF);
    chk("t2_valid", 32'(rx_if.rx_valid), 32'h1);
    chk("t2_overrun", 32'(rx_if.overrun), 32'h1);
    chk("t2_rise_once", 32'(rise_cnt - r0), 32'd1);
    push(10'h3FF, 1'b0);
    @(posedge clk); #1;
    rx_if.rx_ready = 1'b1;
    @(posedge clk); #1;
    chk("t2_valid_fall", 32'(rx_if.rx_valid), 32'h0);
    chk("t2_ovr_clear", 32'(rx_if.overrun), 32'h0);
    wait_empty("t2_drain");
    cs_n = 1'b1; #200;

    // 3: cs_n rises after 6 bits -> single frame_err pulse, then a clean frame
    r0 = rise_cnt; f0 = ferr_cnt;
    cs_n = 1'b0; #100;
    for (int i = 0; i < 6; i++) send_bit(i[0]);
    sclk = 1'b0; #40;
    cs_n = 1'b1; #200;
    chk("t3_ferr_one_clk", 32'(ferr_cnt - f0), 32'd1);
    chk("t3_no_valid", 32'(rise_cnt - r0), 32'd0);
    cs_n = 1'b0; #100;
    push(10'h155, 1'b0);
    send_frame(10'h155, good_par(10'h155));
    wait_empty("t3_drain");
    cs_n = 1'b1; #200;
    chk("t3_data_held", 32'(rx_if.rx_data), 32'h155);

    // 4: async reset after 5 bits -> outputs 0 at once, no frame_err
    f0 = ferr_cnt;
    cs_n = 1'b0; #100;
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t4_rst_data", 32'(rx_if.rx_data), 32'h0);
    chk("t4_rst_valid", 32'(rx_if.rx_valid), 32'h0);
    chk("t4_rst_ovr", 32'(rx_if.overrun), 32'h0);
    chk("t4_rst_ferr", 32'(rx_if.frame_err), 32'h0);
    sclk = 1'b0;
    cs_n = 1'b1; #100;
    rst_n = 1'b1; #100;
    cs_n = 1'b0; #100;
    push(10'h0F0, 1'b0);
    send_frame(10'h0F0, good_par(10'h0F0));
    wait_empty("t4_drain");
    cs_n = 1'b1; #200;
    chk("t4_no_ferr", 32'(ferr_cnt - f0), 32'd0);

`ifdef SPI_RX_PARITY_EN
    // 5: parity bit 1 with data 0x001 is even overall -> parity_err; bit 0 is clean
    p0 = perr_cnt;
    cs_n = 1'b0; #100;
    push(10'h001, 1'b1);
    send_frame(10'h001, 1'b1);
    push(10'h001, 1'b0);
    send_frame(10'h001, 1'b0);
    wait_empty("t5_drain");
    cs_n = 1'b1; #200;
    chk("t5_perr_pulses", 32'(perr_cnt - p0), 32'd1);
`endif

    // 6: sclk activity with cs_n high is ignored
    r0 = rise_cnt; f0 = ferr_cnt; p0 = perr_cnt;
    for (int i = 0; i < 12; i++) send_bit(1'b1);
    sclk = 1'b0; #200;
    chk("t6_no_valid", 32'(rise_cnt - r0), 32'd0);
    chk("t6_no_ferr", 32'(ferr_cnt - f0), 32'd0);
    chk("t6_no_perr", 32'(perr_cnt - p0), 32'd0);
    chk("t6_cnt_zero", 32'(dut.r_cnt), 32'd0);
    cs_n = 1'b0; #100;
    push(10'h15A, 1'b0);
    send_frame(10'h15A, good_par(10'h15A));
    wait_empty("t6_drain");
    cs_n = 1'b1; #200;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
